div_seq: RTL and testbench

- Multi-cycle 32-bit divider sequencer beside the EX stage, serving DIV and DIVU.
- EX asserts start with operands and holds start while it stalls the pipeline.
- div_seq runs a one-bit-per-cycle restoring division under an FSM and returns a 64-bit {remainder, quotient} with a ready flag.
- EX forwards the result to the HI/LO write path (hi = remainder, lo = quotient).

---
 rtl/div_seq_pkg.sv | 19 +
 rtl/div_seq.sv | 147 ++++++++++++++
 tb/tb_div_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared encodings and bus types for the multi-cycle divider sequencer.
// Imported by div_seq and by anything that inspects the divider state.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/div_seq.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, returns
// {remainder, quotient} with a registered ready flag for the HI/LO path.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};

  // Two's complement negation truncated to the operand width.
  function automatic logic [DATA_W-1:0] neg_f(input logic [DATA_W-1:0] v);
    return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] abs_f(input logic [DATA_W-1:0] v,
                                              input logic            is_signed);
    logic [DATA_W-1:0] r;
    if (is_signed && v[DATA_W-1]) begin
      r = neg_f(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

  div_state_e          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*DATA_W:0]   dividend_r;
  logic [DATA_W-1:0]   divisor_r;
  logic                signed_r;
  logic                op1_neg_r;
  logic                op2_neg_r;

  logic [DATA_W:0]     tmp_s;
  logic [DATA_W-1:0]   quot_s;
  logic [DATA_W-1:0]   rem_s;

  // Trial subtract of the partial remainder and sign fix-up of the final result.
  always_comb begin
    tmp_s  = {1'b0, dividend_r[2*DATA_W-1:DATA_W]} - {1'b0, divisor_r};
    quot_s = dividend_r[DATA_W-1:0];
    rem_s  = dividend_r[2*DATA_W:DATA_W+1];
    if (signed_r && (op1_neg_r ^ op2_neg_r)) begin
      quot_s = neg_f(dividend_r[DATA_W-1:0]);
    end else begin
      quot_s = dividend_r[DATA_W-1:0];
    end
    if (signed_r && op1_neg_r) begin
      rem_s = neg_f(dividend_r[2*DATA_W:DATA_W+1]);
    end else begin
      rem_s = dividend_r[2*DATA_W:DATA_W+1];
    end
  end

  // Sequencer FSM with working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= DIV_FREE;
      cnt_r      <= {CNT_W{1'b0}};
      dividend_r <= {(2*DATA_W+1){1'b0}};
      divisor_r  <= ZERO_W;
      signed_r   <= 1'b0;
      op1_neg_r  <= 1'b0;
      op2_neg_r  <= 1'b0;
      result_o   <= {(2*DATA_W){1'b0}};
      ready_o    <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_r)
        DIV_FREE: begin
          result_o <= {(2*DATA_W){1'b0}};
          ready_o  <= DIV_RESULT_NOT_READY;
          if ((start_i == DIV_START) && !annul_i) begin
            if (opdata2_i == ZERO_W) begin
              state_r <= DIV_BYZERO;
            end else begin
              state_r    <= DIV_ON;
              signed_r   <= signed_div_i;
              op1_neg_r  <= opdata1_i[DATA_W-1];
              op2_neg_r  <= opdata2_i[DATA_W-1];
              dividend_r <= {ZERO_W, abs_f(opdata1_i, signed_div_i), 1'b0};
              divisor_r  <= abs_f(opdata2_i, signed_div_i);
              cnt_r      <= {CNT_W{1'b0}};
            end
          end else begin
            state_r <= DIV_FREE;
          end
        end
        DIV_BYZERO: begin
          state_r    <= DIV_END;
          cnt_r      <= {CNT_W{1'b0}};
          dividend_r <= {(2*DATA_W+1){1'b0}};
          divisor_r  <= ZERO_W;
          result_o   <= {(2*DATA_W){1'b0}};
          ready_o    <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i) begin
            // Flushed: drop the division without ever raising ready.
            state_r  <= DIV_FREE;
            result_o <= {(2*DATA_W){1'b0}};
            ready_o  <= DIV_RESULT_NOT_READY;
          end else if (cnt_r != CNT_DONE) begin
            if (tmp_s[DATA_W]) begin
              dividend_r <= {dividend_r[2*DATA_W-1:0], 1'b0};
            end else begin
              dividend_r <= {tmp_s[DATA_W-1:0], dividend_r[DATA_W-1:0], 1'b1};
            end
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            state_r  <= DIV_END;
            result_o <= {rem_s, quot_s};
            ready_o  <= DIV_RESULT_READY;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state_r  <= DIV_FREE;
            result_o <= {(2*DATA_W){1'b0}};
            ready_o  <= DIV_RESULT_NOT_READY;
          end else begin
            state_r <= DIV_END;
          end
        end
        default: begin
          state_r  <= DIV_FREE;
          result_o <= {(2*DATA_W){1'b0}};
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq with hand-computed expectations.
module tb_div_seq;
  import div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Accept at edge 1, stay busy through edge 33, ready with result after edge 34.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit noise);
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    annul = 1'b0;
    tick();
    for (int e = 2; e <= 33; e++) begin
      if (noise) begin
        op1 = $urandom;
        op2 = $urandom;
        start = (e == 6) ? 1'b0 : 1'b1;
      end
      tick();
    end
    start = 1'b1;
    check({tag, "_busy33"}, {63'd0, ready}, 64'd0);
    tick();
    check({tag, "_ready34"}, {63'd0, ready}, 64'd1);
    check({tag, "_result"}, result, exp);
  endtask

  task automatic drop(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_drop_ready"}, {63'd0, ready}, 64'd0);
    check({tag, "_drop_result"}, result, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_state", {62'd0, dut.state_r}, {62'd0, DIV_FREE});

    // Unsigned 100/7 = 14 rem 2, result held while start stays high.
    run_div("udiv", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    tick();
    check("udiv_hold_ready", {63'd0, ready}, 64'd1);
    check("udiv_hold_result", result, 64'h00000002_0000000E);
    drop("udiv");

    // Signed -7/2 = -3 rem -1.
    run_div("sdiv", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    drop("sdiv");

    // Signed overflow wraps without trapping.
    run_div("sovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    drop("sovf");

    // Operand noise and a start glitch during ON must not disturb 100/7.
    run_div("noise", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
    drop("noise");

    // Divide by zero: ready after edge 2 with a zero result.
    signed_div = 1'b0;
    op1 = 32'h00001234;
    op2 = 32'd0;
    start = 1'b1;
    tick();
    check("dbz_edge1_ready", {63'd0, ready}, 64'd0);
    tick();
    check("dbz_edge2_ready", {63'd0, ready}, 64'd1);
    check("dbz_result", result, 64'd0);
    drop("dbz");

    // Annul in FREE blocks acceptance.
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    annul = 1'b1;
    tick();
    check("annul_free_state", {62'd0, dut.state_r}, {62'd0, DIV_FREE});
    annul = 1'b0;

    // Annul at edge 10 of ON, then a fresh 50/5 the following cycle.
    tick();
    for (int e = 2; e <= 9; e++) tick();
    annul = 1'b1;
    tick();
    check("annul_on_state", {62'd0, dut.state_r}, {62'd0, DIV_FREE});
    check("annul_on_ready", {63'd0, ready}, 64'd0);
    run_div("post_annul", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 1'b0);
    drop("post_annul");

    // Reset in the middle of ON, then 9/3.
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    tick();
    for (int e = 2; e <= 19; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_state", {62'd0, dut.state_r}, {62'd0, DIV_FREE});
    run_div("post_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);
    drop("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
